// File: rtl/dma_periph_endpoint.sv
// Peripheral-side endpoint of the DMA request/acknowledge handshake.
// A word FIFO sits between the local device and the DMA controller. When enough
// data (dev->mem) or space (mem->dev) is available, dreq is raised and the
// controller moves up to BURST words, one per acknowledged cycle.
module dma_periph_endpoint #(
    parameter int DW    = 8,
    parameter int DEPTH = 16,
    parameter int BURST = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enable,
    input  logic                       mode,
    input  logic                       loc_valid,
    input  logic [DW-1:0]              loc_din,
    output logic                       loc_ready,
    input  logic                       loc_pop,
    output logic [DW-1:0]              loc_dout,
    output logic                       loc_avail,
    output logic                       dreq,
    input  logic                       dack,
    input  logic                       tc,
    input  logic [DW-1:0]              dma_din,
    output logic [DW-1:0]              dma_dout,
    output logic                       eop,
    output logic                       err,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = $clog2(BURST) + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic            mode_q, mode_d;
    logic            dreq_q, dreq_d;
    logic            eop_q, eop_d;
    logic            err_q, err_d;
    logic [LW-1:0]   level_q, level_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [DW-1:0]   mem_q [DEPTH];

    logic            mode_eff_s;
    logic            full_s;
    logic            empty_s;
    logic            beat_s;
    logic            push_s;
    logic            pop_s;
    logic            thresh_s;
    logic [DW-1:0]   wdata_s;

    // FIFO datapath: in IDLE the live mode input governs, otherwise the latched one.
    always_comb begin
        mode_eff_s = (state_q == ST_IDLE) ? mode : mode_q;
        full_s     = (level_q == LW'(DEPTH));
        empty_s    = (level_q == {LW{1'b0}});
        beat_s     = dreq_q & dack;
        if (mode_eff_s) begin
            push_s   = beat_s;
            pop_s    = loc_pop & ~empty_s;
            wdata_s  = dma_din;
            thresh_s = ((LW'(DEPTH) - level_q) >= LW'(BURST));
        end else begin
            push_s   = loc_valid & ~full_s;
            pop_s    = beat_s;
            wdata_s  = loc_din;
            thresh_s = (level_q >= LW'(BURST));
        end
        level_d  = level_q + LW'(push_s) - LW'(pop_s);
        wr_ptr_d = wr_ptr_q + AW'(push_s);
        rd_ptr_d = rd_ptr_q + AW'(pop_s);
    end

    // Request FSM: next state, beat counter, request and end-of-process pulse.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        cnt_d   = cnt_q;
        dreq_d  = dreq_q;
        eop_d   = 1'b0;
        err_d   = err_q | (dack & ~dreq_q);
        case (state_q)
            ST_IDLE: begin
                mode_d = mode;
                cnt_d  = {CW{1'b0}};
                if (enable && thresh_s) begin
                    state_d = ST_XFER;
                    dreq_d  = 1'b1;
                end else begin
                    dreq_d  = 1'b0;
                end
            end
            ST_XFER: begin
                if (beat_s && tc) begin
                    state_d = ST_DONE;
                    dreq_d  = 1'b0;
                    eop_d   = 1'b1;
                    cnt_d   = {CW{1'b0}};
                end else if (beat_s && (cnt_q == CW'(BURST - 1))) begin
                    state_d = ST_IDLE;
                    dreq_d  = 1'b0;
                    cnt_d   = {CW{1'b0}};
                end else if (beat_s) begin
                    cnt_d   = cnt_q + CW'(1);
                end else begin
                    dreq_d  = 1'b1;
                end
            end
            ST_DONE: begin
                dreq_d = 1'b0;
                if (!enable) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                dreq_d  = 1'b0;
                cnt_d   = {CW{1'b0}};
            end
        endcase
    end

    // State, control and FIFO pointer registers; reset empties the FIFO at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            mode_q   <= 1'b0;
            cnt_q    <= {CW{1'b0}};
            dreq_q   <= 1'b0;
            eop_q    <= 1'b0;
            err_q    <= 1'b0;
            level_q  <= {LW{1'b0}};
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            cnt_q    <= cnt_d;
            dreq_q   <= dreq_d;
            eop_q    <= eop_d;
            err_q    <= err_d;
            level_q  <= level_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // FIFO storage; contents are only meaningful between the pointers.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= wdata_s;
        end
    end

    assign loc_ready = ~full_s & ~mode_eff_s;
    assign loc_avail = ~empty_s & mode_eff_s;
    assign loc_dout  = mem_q[rd_ptr_q];
    assign dma_dout  = mem_q[rd_ptr_q];
    assign dreq      = dreq_q;
    assign eop       = eop_q;
    assign err       = err_q;
    assign level     = level_q;

endmodule
